// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: walks ROM slot addresses, captures each word and hands it to decode via valid/ready.
// Define FETCH_HALT_EN to stop fetching after the default NOP word (0x8B1F03FF) is accepted.
module instr_fetch_unit #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned ROM_LATENCY = 1,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_en,
  output logic [31:0]         rom_addr,
  input  logic [63:0]         instr_in,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [31:0]         instr_out,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic                fetch_busy,
  output logic                halted
);

  localparam int unsigned WAIT_W    = 4;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(ROM_LATENCY - 1);
`ifdef FETCH_HALT_EN
  localparam logic [31:0] NOP_WORD = 32'h8B1F_03FF;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [WAIT_W-1:0]   wait_q;
  logic [31:0]         rom_addr_q;
  logic [31:0]         instr_out_q;
  logic [PC_WIDTH-1:0] instr_pc_q;
  logic                instr_valid_q;
  logic                fetch_busy_q;
  logic                halted_q;
  logic                accept;
  logic                unused_instr_hi;

  // Slot index sits in address[19:12]; the low 12 bits are always all-ones.
  function automatic logic [31:0] slot_addr(input logic [PC_WIDTH-1:0] slot);
    return {12'h000, 8'(slot), 12'hFFF};
  endfunction

  assign pc_inc          = pc_q + PC_WIDTH'(1);
  assign accept          = instr_valid_q & instr_ready;
  assign unused_instr_hi = ^instr_in[63:32];

  // Fetch sequencer; a redirect always beats sequential advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= PC_WIDTH'(RESET_PC);
      wait_q        <= '0;
      rom_addr_q    <= '0;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_busy_q  <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (redirect_valid) pc_q <= redirect_pc;
          if (fetch_en) begin
            state_q      <= S_REQ;
            wait_q       <= WAIT_INIT;
            fetch_busy_q <= 1'b1;
            rom_addr_q   <= slot_addr(redirect_valid ? redirect_pc : pc_q);
          end
        end

        S_REQ: begin
          if (redirect_valid) begin
            pc_q   <= redirect_pc;
            wait_q <= WAIT_INIT;
            if (fetch_en) begin
              rom_addr_q <= slot_addr(redirect_pc);
            end else begin
              state_q      <= S_IDLE;
              rom_addr_q   <= '0;
              fetch_busy_q <= 1'b0;
            end
          end else if (wait_q != '0) begin
            wait_q <= wait_q - WAIT_W'(1);
          end else begin
            instr_out_q   <= instr_in[31:0];
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            state_q       <= S_HOLD;
            rom_addr_q    <= '0;
            fetch_busy_q  <= 1'b0;
          end
        end

        S_HOLD: begin
          if (redirect_valid) begin
            // Held word is either consumed this cycle or dropped; both restart at the target.
            instr_valid_q <= 1'b0;
            pc_q          <= redirect_pc;
            state_q       <= S_REQ;
            wait_q        <= WAIT_INIT;
            rom_addr_q    <= slot_addr(redirect_pc);
            fetch_busy_q  <= 1'b1;
          end else if (accept) begin
            instr_valid_q <= 1'b0;
            pc_q          <= pc_inc;
`ifdef FETCH_HALT_EN
            if (instr_out_q == NOP_WORD) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else
`endif
            if (fetch_en) begin
              state_q      <= S_REQ;
              wait_q       <= WAIT_INIT;
              rom_addr_q   <= slot_addr(pc_inc);
              fetch_busy_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end

        S_HALT: begin
          if (redirect_valid) begin
            pc_q         <= redirect_pc;
            halted_q     <= 1'b0;
            state_q      <= S_REQ;
            wait_q       <= WAIT_INIT;
            rom_addr_q   <= slot_addr(redirect_pc);
            fetch_busy_q <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_addr    = rom_addr_q;
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_busy  = fetch_busy_q;
  assign halted      = halted_q;

endmodule
